// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encoding and constants for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_OUT  = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Next-PC mux: sequential pc+4 or word-aligned redirect target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] branch_PC,
    input  logic [WIDTH-1:0] ImmOP,
    input  logic             PCsrc,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);

    logic [WIDTH-1:0] w_target_raw;

    assign w_target_raw = branch_PC + ImmOP;

    // Low two bits are dropped rather than trapped; the flag reports it.
    assign next_pc    = PCsrc ? {w_target_raw[WIDTH-1:2], 2'b00}
                              : pc + WIDTH'(INSTR_BYTES);
    assign misaligned = PCsrc && (w_target_raw[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : PC register plus single-outstanding instruction fetch FSM.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] branch_PC,
    input  logic [WIDTH-1:0] ImmOP,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             misaligned
);

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_drop;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_instr_pc;
    logic             r_misaligned;

    logic [WIDTH-1:0] w_next_pc;
    logic             w_misaligned;
    logic             w_redirect;

    pc_next_sel #(
        .WIDTH (WIDTH)
    ) u_pc_next_sel (
        .pc         (r_pc),
        .branch_PC  (branch_PC),
        .ImmOP      (ImmOP),
        .PCsrc      (PCsrc),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    assign w_redirect = PCsrc && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            if (w_redirect) begin
                r_pc         <= w_next_pc;
                r_misaligned <= w_misaligned;
            end
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (imem_gnt) begin
                        r_state <= S_RESP;
                        // A grant in the redirect cycle fetched the old pc.
                        if (w_redirect) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (imem_rvalid) begin
                        if (w_redirect || r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_instr    <= imem_rdata;
                            r_instr_pc <= r_pc;
                            r_state    <= S_OUT;
                        end
                    end else if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_redirect) begin
                        r_state <= S_REQ;
                    end else if (instr_ready) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign instr_valid = (r_state == S_OUT);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign misaligned  = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Randomized + directed scoreboard bench for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCsrc = 1'b0;
    logic [31:0] branch_PC = '0;
    logic [31:0] ImmOP = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misaligned;

    fetch_sequencer #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCsrc       (PCsrc),
        .branch_PC   (branch_PC),
        .ImmOP       (ImmOP),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;

    // Expected redirect outcomes, pushed by the driver, popped by the monitor.
    logic [31:0] tgt_q[$];
    logic        mis_q[$];

    // Memory model configuration and state.
    bit          gnt_always = 1'b1;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wait_cnt = 0;
    bit          last_rst = 1'b1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs for the coming edge, take it, update memory model.
    task automatic cyc(input logic r, input logic redir, input logic [31:0] bpc,
                       input logic [31:0] imm, input logic rdy);
        logic [31:0] raw;
        logic        s_req;
        logic [31:0] s_addr;
        s_req  = imem_req;
        s_addr = imem_addr;
        rst    = r;
        imem_gnt = s_req ? (gnt_always || ($urandom_range(0, 2) != 0))
                         : ($urandom_range(0, 1) == 1);
        if (pend && wait_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(pend_addr);
        end else begin
            imem_rvalid = !pend && ($urandom_range(0, 3) == 0);
            imem_rdata  = $urandom;
        end
        PCsrc       = redir;
        branch_PC   = redir ? bpc : $urandom;
        ImmOP       = redir ? imm : $urandom;
        instr_ready = rdy;
        if (redir && !r && !last_rst) begin
            raw = bpc + imm;
            tgt_q.push_back({raw[31:2], 2'b00});
            mis_q.push_back(raw[1:0] != 2'b00);
        end
        @(posedge clk);
        #1;
        if (r) begin
            pend = 1'b0;
        end else if (pend) begin
            if (imem_rvalid) pend = 1'b0;
            else if (wait_cnt > 0) wait_cnt--;
        end else if (s_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            wait_cnt  = $urandom_range(lat_min, lat_max);
        end
        last_rst = r;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 30) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        chk(name, instr_valid, 1'b1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 30) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        chk(name, imem_req, 1'b1);
    endtask

    // Monitor: architectural model of "next instruction to deliver".
    logic [31:0] exp_pc = RESET_PC;
    logic        exp_mis = 1'b0;
    bit          was_rst = 1'b0;
    bit          chk_en = 1'b0;
    bit          hold_req = 1'b0;
    int          stall = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (was_rst) begin
                chk("rst_req", imem_req, 1'b0);
                chk("rst_valid", instr_valid, 1'b0);
                chk("rst_addr", imem_addr, RESET_PC);
                chk("rst_instr", instr, 32'h0);
                chk("rst_instr_pc", instr_pc, 32'h0);
                chk("rst_misaligned", misaligned, 1'b0);
            end else begin
                chk("misaligned", misaligned, exp_mis);
                if (hold_req) chk("req_held", imem_req, 1'b1);
                if (imem_req) chk("fetch_addr", imem_addr, exp_pc);
                if (instr_valid) begin
                    chk("instr_pc", instr_pc, exp_pc);
                    chk("instr_data", instr, memf(exp_pc));
                    chk("req_valid_excl", imem_req, 1'b0);
                end
                if (stall >= 60) begin
                    chk("progress", stall, 0);
                    stall = 0;
                end
            end
        end
        hold_req = chk_en && !rst && imem_req && !imem_gnt;
        exp_mis  = 1'b0;
        if (rst) begin
            exp_pc  = RESET_PC;
            was_rst = 1'b1;
            chk_en  = 1'b1;
            stall   = 0;
        end else begin
            if (chk_en && !was_rst) begin
                if (PCsrc) begin
                    if (tgt_q.size() > 0) begin
                        exp_pc  = tgt_q.pop_front();
                        exp_mis = mis_q.pop_front();
                    end else begin
                        chk("redirect_queue", tgt_q.size(), 1);
                    end
                    stall = 0;
                end else if (instr_valid && instr_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    n_deliv++;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
            was_rst = 1'b0;
        end
    end

    initial begin
        logic [31:0] cap_instr;
        logic [31:0] cap_pc;
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Zero-wait memory, ready high; a redirect in S_IDLE must be ignored.
        gnt_always = 1'b1; lat_min = 0; lat_max = 0;
        cyc(1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            chk("req_pattern", imem_req, (k % 3) == 1);
            chk("valid_pattern", instr_valid, (k % 3) == 0);
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end

        // Backpressure: hold the instruction for 5 cycles.
        wait_valid("wait_bp_valid");
        cap_instr = instr;
        cap_pc    = instr_pc;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk("bp_valid", instr_valid, 1'b1);
            chk("bp_instr", instr, cap_instr);
            chk("bp_req", imem_req, 1'b0);
        end
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("bp_next_addr", imem_addr, cap_pc + 32'd4);

        // Redirect while waiting for the response to 0x10.
        lat_min = 2; lat_max = 2;
        wait_req("wait_req_resp");
        chk("resp_pc", imem_addr, 32'h10);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h10, 32'hFFFF_FFF0, 1'b1);
        wait_valid("wait_resp_redir");
        chk("resp_redir_pc", instr_pc, 32'h0);

        // Redirect colliding with a grant.
        lat_min = 0; lat_max = 0;
        wait_req("wait_req_gnt");
        cyc(1'b0, 1'b1, 32'h200, 32'h20, 1'b1);
        wait_valid("wait_gnt_redir");
        chk("gnt_redir_pc", instr_pc, 32'h220);

        // Redirect colliding with instr_ready.
        cyc(1'b0, 1'b1, 32'h300, 32'h0, 1'b1);
        chk("out_squash", instr_valid, 1'b0);
        wait_valid("wait_out_redir");
        chk("out_redir_pc", instr_pc, 32'h300);

        // Misaligned target.
        wait_req("wait_req_mis");
        cyc(1'b0, 1'b1, 32'h100, 32'h6, 1'b1);
        chk("mis_pulse", misaligned, 1'b1);
        chk("mis_addr", imem_addr, 32'h104);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("mis_clear", misaligned, 1'b0);

        // PC wrap.
        cyc(1'b0, 1'b1, 32'hFFFF_FFF0, 32'hC, 1'b1);
        wait_valid("wait_wrap");
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("wrap_req", imem_req, 1'b1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset in the middle of a fetch.
        lat_min = 2; lat_max = 2;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("mid_in_resp", imem_req | instr_valid, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("mid_rst_addr", imem_addr, RESET_PC);
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_valid", instr_valid, 1'b0);

        // Randomized traffic with random memory timing, redirects and resets.
        gnt_always = 1'b0; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 15) == 0),
                $urandom,
                ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32),
                ($urandom_range(0, 3) != 0));
        end
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("deliveries", n_deliv >= 30, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
